booth_seq_mul: RTL

- Iterative radix-4 Booth multiplier for the NPC execute stage.
- Encoder side of the Booth datapath. Each cycle it scans one multiplier triplet, emits the 4-bit one-hot select (same encoding the partial-product bit generators consume), and adds the selected partial product into an accumulator.
- Valid/ready on input and output, plus a pipeline flush.

---
 rtl/booth_seq_mul_pkg.sv | 19 +
 rtl/booth_sel_enc.sv | 21 ++
 rtl/booth_seq_mul.sv | 132 +++++++++++++
 3 files changed

// File: rtl/booth_seq_mul_pkg.sv
// Shared encodings for the radix-4 Booth sequential multiplier:
// select-bit positions, FSM states and io_signed bit positions.
package booth_seq_mul_pkg;

  localparam int SEL_NEG  = 0;
  localparam int SEL_POS  = 1;
  localparam int SEL_DNEG = 2;
  localparam int SEL_DPOS = 3;

  localparam int SIGN_A_BIT = 1;
  localparam int SIGN_B_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_sel_enc.sv
// Radix-4 Booth triplet encoder: {y[2i+1], y[2i], y[2i-1]} to a one-hot
// select in the same encoding the partial-product bit generators consume.
module booth_sel_enc
  import booth_seq_mul_pkg::*;
(
  input  logic [2:0] trip_i,
  output logic [3:0] sel_o
);

  always_comb begin
    sel_o = '0;
    case (trip_i)
      3'b001, 3'b010: sel_o[SEL_POS]  = 1'b1;
      3'b011:         sel_o[SEL_DPOS] = 1'b1;
      3'b100:         sel_o[SEL_DNEG] = 1'b1;
      3'b101, 3'b110: sel_o[SEL_NEG]  = 1'b1;
      default:        sel_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier: one multiplier triplet per cycle,
// partial product added into a 2*XLEN+4 accumulator, valid/ready + flush.
module booth_seq_mul
  import booth_seq_mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_in_valid,
  output logic            io_in_ready,
  input  logic [XLEN-1:0] io_a,
  input  logic [XLEN-1:0] io_b,
  input  logic [1:0]      io_signed,
  input  logic            io_flush,
  output logic            io_out_valid,
  input  logic            io_out_ready,
  output logic [XLEN-1:0] io_result_hi,
  output logic [XLEN-1:0] io_result_lo,
  output logic [3:0]      io_sel
);

  localparam int STEPS = (XLEN + 2) / 2;
  localparam int EXTW  = XLEN + 2;
  localparam int ACCW  = 2 * XLEN + 4;
  localparam int CNTW  = $clog2(STEPS + 1);

  state_e          state_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_d;
  logic [ACCW-1:0] m_q;
  logic [EXTW:0]   y_q;
  logic [CNTW-1:0] cnt_q;

  logic [EXTW-1:0] a_ext;
  logic [EXTW-1:0] b_ext;
  logic [ACCW-1:0] m_load;
  logic [3:0]      sel_raw;
  logic [ACCW-1:0] pp_mag;
  logic            pp_cin;

  assign a_ext  = {{2{io_signed[SIGN_A_BIT] & io_a[XLEN-1]}}, io_a};
  assign b_ext  = {{2{io_signed[SIGN_B_BIT] & io_b[XLEN-1]}}, io_b};
  assign m_load = {{(ACCW-EXTW){a_ext[EXTW-1]}}, a_ext};

  booth_sel_enc u_sel_enc (
    .trip_i (y_q[2:0]),
    .sel_o  (sel_raw)
  );

  // Negative selects invert the (pre-shifted) multiplicand and feed a +1
  // carry into the accumulator add, so no negated copy is ever stored.
  always_comb begin
    pp_mag = '0;
    pp_cin = 1'b0;
    if (sel_raw[SEL_POS]) begin
      pp_mag = m_q;
    end else if (sel_raw[SEL_DPOS]) begin
      pp_mag = m_q << 1;
    end else if (sel_raw[SEL_NEG]) begin
      pp_mag = ~m_q;
      pp_cin = 1'b1;
    end else if (sel_raw[SEL_DNEG]) begin
      pp_mag = ~(m_q << 1);
      pp_cin = 1'b1;
    end
    acc_d = acc_q + pp_mag + {{(ACCW-1){1'b0}}, pp_cin};
  end

  // Handshake: an operand transfer happens on an edge with io_in_valid &
  // io_in_ready & !io_flush; a result transfer on an edge with
  // io_out_valid & io_out_ready. Result holds steady while valid & !ready.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      m_q         <= '0;
      y_q         <= '0;
      cnt_q       <= '0;
    end else if (io_flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io_in_valid) begin
            m_q        <= m_load;
            y_q        <= {b_ext, 1'b0};
            acc_q      <= '0;
            cnt_q      <= '0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          m_q   <= m_q << 2;
          y_q   <= y_q >> 2;
          cnt_q <= cnt_q + CNTW'(1);
          if (cnt_q == CNTW'(STEPS - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign io_in_ready  = in_ready_q;
  assign io_out_valid = out_valid_q;
  assign io_result_hi = acc_q[2*XLEN-1:XLEN];
  assign io_result_lo = acc_q[XLEN-1:0];
  assign io_sel       = (state_q == BUSY) ? sel_raw : 4'b0000;

endmodule
